// File: rtl/keyword_tokenizer.sv
// Splits an ASCII byte stream into space-delimited words, classifies each word
// as BEGIN / END / OTHER (case-insensitive) and queues the tokens in a small FIFO.
module keyword_tokenizer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in,
    input  logic             in_valid,
    input  logic             eos,
    input  logic             tok_ready,
    output logic             tok_valid,
    output logic [1:0]       tok_type,
    output logic [CNT_W-1:0] word_cnt,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [3:0] {
        IDLE, B1, B2, B3, B4, BK, E1, E2, EK, OTH
    } state_t;

    state_t state, after_state, next_state;

    logic [7:0]  lc;
    logic        is_space;
    logic        word_byte;
    logic        terminate;
    logic [1:0]  push_type;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [1:0]  mem [FIFO_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A non-space byte advances the FSM first; the terminator then sees the resulting state.
    always_comb begin
        lc          = in | 8'h20;
        is_space    = (in == 8'd32);
        word_byte   = in_valid && !is_space;
        after_state = state;
        if (word_byte) begin
            case (state)
                IDLE:    after_state = (lc == 8'h62) ? B1 : ((lc == 8'h65) ? E1 : OTH);
                B1:      after_state = (lc == 8'h65) ? B2 : OTH;
                B2:      after_state = (lc == 8'h67) ? B3 : OTH;
                B3:      after_state = (lc == 8'h69) ? B4 : OTH;
                B4:      after_state = (lc == 8'h6e) ? BK : OTH;
                E1:      after_state = (lc == 8'h6e) ? E2 : OTH;
                E2:      after_state = (lc == 8'h64) ? EK : OTH;
                default: after_state = OTH;
            endcase
        end
        terminate  = (after_state != IDLE) && ((in_valid && is_space) || eos);
        push_type  = (after_state == BK) ? 2'b01 : ((after_state == EK) ? 2'b10 : 2'b11);
        next_state = terminate ? IDLE : after_state;
    end

    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop       = !empty && tok_ready;
        push      = terminate && (!full || pop);
        tok_valid = !empty;
        tok_type  = empty ? 2'b00 : mem[rd_ptr[AW-1:0]];
    end

    // A full FIFO with a simultaneous pop frees the head slot, so the push may reuse it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_cnt <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 2'b00;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_type;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (terminate && full && !pop) begin
                overflow <= 1'b1;
            end
            if (terminate && (word_cnt != '1)) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_keyword_tokenizer.sv
// Self-checking bench for keyword_tokenizer: directed scenarios plus random streams,
// compared against a word-buffer / token-queue reference model.
module tb_keyword_tokenizer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [7:0]  in;
    logic        in_valid;
    logic        eos;
    logic        tok_ready;
    logic        tok_valid;
    logic [1:0]  tok_type;
    logic [15:0] word_cnt;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] word_q [$];
    logic [1:0] fifo_q [$];
    int         cnt;
    bit         ovf;

    keyword_tokenizer #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .eos       (eos),
        .tok_ready (tok_ready),
        .tok_valid (tok_valid),
        .tok_type  (tok_type),
        .word_cnt  (word_cnt),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit word_is(input string kw);
        if (word_q.size() != kw.len()) return 1'b0;
        for (int i = 0; i < kw.len(); i++) begin
            if (word_q[i] != kw[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        word_q.delete();
        fifo_q.delete();
        cnt = 0;
        ovf = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] c, input logic v, input logic e, input logic r);
        bit         do_pop;
        bit         term;
        logic [1:0] t;
        logic [7:0] low;
        do_pop = (fifo_q.size() > 0) && r;
        if (v && c != 8'd32) begin
            low = (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
            word_q.push_back(low);
        end
        term = (word_q.size() > 0) && ((v && c == 8'd32) || e);
        t    = 2'b11;
        if (term) begin
            if (word_is("begin"))    t = 2'b01;
            else if (word_is("end")) t = 2'b10;
            if (cnt < 65535) cnt++;
            word_q.delete();
        end
        if (do_pop) void'(fifo_q.pop_front());
        if (term) begin
            if (fifo_q.size() < DEPTH) fifo_q.push_back(t);
            else ovf = 1'b1;
        end
    endfunction

    function automatic logic [19:0] model_out();
        logic [1:0] t;
        t = (fifo_q.size() > 0) ? fifo_q[0] : 2'b00;
        return {fifo_q.size() > 0, t, 16'(cnt), ovf};
    endfunction

    task automatic drive(input logic [7:0] c, input logic v, input logic e, input logic r);
        in        = c;
        in_valid  = v;
        eos       = e;
        tok_ready = r;
        @(posedge clk);
        model_step(c, v, e, r);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        in        = 8'h00;
        in_valid  = 1'b0;
        eos       = 1'b0;
        tok_ready = 1'b0;
        model_reset();
        #12;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if ({tok_valid, tok_type, word_cnt, overflow} !== 20'h0) begin
            failures++;
            $display("[TB] FAIL reset_during: got %h expected %h", {tok_valid, tok_type, word_cnt, overflow}, 20'h0);
        end
        apply_reset();
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({tok_valid, tok_type, word_cnt, overflow} !== 20'h0) begin
            failures++;
            $display("[TB] FAIL reset_after: got %h expected %h", {tok_valid, tok_type, word_cnt, overflow}, 20'h0);
        end
    endtask

    task automatic test_begin_end();
        string s = "begin end";
        apply_reset();
        for (int i = 0; i <= s.len(); i++) begin
            if (i < s.len()) drive(s[i], 1'b1, 1'b0, 1'b1);
            else             drive(8'h00, 1'b0, 1'b1, 1'b1);
            checks++;
            if ({tok_valid, tok_type, word_cnt, overflow} !== model_out()) begin
                failures++;
                $display("[TB] FAIL begin_end[%0d]: got %h expected %h", i, {tok_valid, tok_type, word_cnt, overflow}, model_out());
            end
            if (i == 5) begin
                checks++;
                if ({tok_valid, tok_type} !== 3'b101) begin
                    failures++;
                    $display("[TB] FAIL begin_token: got %b expected 101", {tok_valid, tok_type});
                end
            end
        end
        checks++;
        if ({tok_valid, tok_type, word_cnt, overflow} !== {1'b1, 2'b10, 16'd2, 1'b0}) begin
            failures++;
            $display("[TB] FAIL end_token: got %h expected %h", {tok_valid, tok_type, word_cnt, overflow}, {1'b1, 2'b10, 16'd2, 1'b0});
        end
    endtask

    task automatic test_same_edge_eos();
        string s = "BeGiN";
        apply_reset();
        for (int i = 0; i < s.len(); i++) begin
            drive(s[i], 1'b1, i == s.len() - 1, 1'b0);
            checks++;
            if ({tok_valid, tok_type, word_cnt, overflow} !== model_out()) begin
                failures++;
                $display("[TB] FAIL same_edge[%0d]: got %h expected %h", i, {tok_valid, tok_type, word_cnt, overflow}, model_out());
            end
        end
        drive(8'h00, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({tok_valid, tok_type, word_cnt} !== {1'b0, 2'b00, 16'd1}) begin
            failures++;
            $display("[TB] FAIL same_edge_single: got %h expected %h", {tok_valid, tok_type, word_cnt}, {1'b0, 2'b00, 16'd1});
        end
    endtask

    task automatic test_mismatch();
        string s = "beginx en endd d";
        apply_reset();
        for (int i = 0; i < s.len(); i++) begin
            drive(s[i], 1'b1, i == s.len() - 1, 1'b1);
            checks++;
            if ({tok_valid, tok_type, word_cnt, overflow} !== model_out()) begin
                failures++;
                $display("[TB] FAIL mismatch[%0d]: got %h expected %h", i, {tok_valid, tok_type, word_cnt, overflow}, model_out());
            end
        end
        checks++;
        if (word_cnt !== 16'd4) begin
            failures++;
            $display("[TB] FAIL mismatch_cnt: got %0d expected 4", word_cnt);
        end
    endtask

    task automatic test_sparse_valid();
        string s = "   end   ";
        int    seen = 0;
        apply_reset();
        for (int i = 0; i < s.len(); i++) begin
            drive(s[i], 1'b1, 1'b0, 1'b1);
            if (tok_valid) seen++;
            drive(8'h20, 1'b0, 1'b0, 1'b1);
            checks++;
            if ({tok_valid, tok_type, word_cnt, overflow} !== model_out()) begin
                failures++;
                $display("[TB] FAIL sparse[%0d]: got %h expected %h", i, {tok_valid, tok_type, word_cnt, overflow}, model_out());
            end
        end
        checks++;
        if (seen != 1 || word_cnt !== 16'd1) begin
            failures++;
            $display("[TB] FAIL sparse_count: got tokens=%0d cnt=%0d expected tokens=1 cnt=1", seen, word_cnt);
        end
    endtask

    task automatic test_overflow();
        string s = "a b c d e ";
        apply_reset();
        for (int i = 0; i < s.len(); i++) begin
            drive(s[i], 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if ({tok_valid, tok_type, word_cnt, overflow} !== {1'b1, 2'b11, 16'd5, 1'b1}) begin
            failures++;
            $display("[TB] FAIL overflow_full: got %h expected %h", {tok_valid, tok_type, word_cnt, overflow}, {1'b1, 2'b11, 16'd5, 1'b1});
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(8'h00, 1'b0, 1'b0, 1'b1);
            checks++;
            if ({tok_valid, tok_type, word_cnt, overflow} !== model_out()) begin
                failures++;
                $display("[TB] FAIL overflow_drain[%0d]: got %h expected %h", i, {tok_valid, tok_type, word_cnt, overflow}, model_out());
            end
        end
        checks++;
        if ({tok_valid, overflow} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL overflow_sticky: got %b expected 01", {tok_valid, overflow});
        end
    endtask

    task automatic test_async_reset();
        string s1 = "begi";
        string s2 = "end ";
        apply_reset();
        for (int i = 0; i < s1.len(); i++) begin
            drive(s1[i], 1'b1, 1'b0, 1'b0);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({tok_valid, tok_type, word_cnt, overflow} !== 20'h0) begin
            failures++;
            $display("[TB] FAIL async_reset: got %h expected %h", {tok_valid, tok_type, word_cnt, overflow}, 20'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < s2.len(); i++) begin
            drive(s2[i], 1'b1, 1'b0, 1'b0);
            checks++;
            if ({tok_valid, tok_type, word_cnt, overflow} !== model_out()) begin
                failures++;
                $display("[TB] FAIL async_after[%0d]: got %h expected %h", i, {tok_valid, tok_type, word_cnt, overflow}, model_out());
            end
        end
        checks++;
        if ({tok_valid, tok_type, word_cnt} !== {1'b1, 2'b10, 16'd1}) begin
            failures++;
            $display("[TB] FAIL async_token: got %h expected %h", {tok_valid, tok_type, word_cnt}, {1'b1, 2'b10, 16'd1});
        end
    endtask

    task automatic test_random();
        string pool = "bBeEgGiInNdDx   z";
        logic [7:0] c;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            c = pool[$urandom_range(0, pool.len() - 1)];
            drive(c, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
            checks++;
            if ({tok_valid, tok_type, word_cnt, overflow} !== model_out()) begin
                failures++;
                $display("[TB] FAIL random[%0d]: got %h expected %h", i, {tok_valid, tok_type, word_cnt, overflow}, model_out());
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        in        = 8'h00;
        in_valid  = 1'b0;
        eos       = 1'b0;
        tok_ready = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_begin_end();
        test_same_edge_eos();
        test_mismatch();
        test_sparse_valid();
        test_overflow();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keyword_tokenizer.md
Name: keyword_tokenizer

Overview:
- Upstream stage of the begin/end nesting checker.
- Consumes the raw ASCII character stream, one byte per clock when valid.
- Splits the stream into space-delimited words and classifies each word case-insensitively as BEGIN, END or OTHER.
- Queues the classified tokens in a small FIFO with a valid/ready handshake, so the nesting checker can consume one token at a time instead of raw characters.

Parameters:
- FIFO_DEPTH, 4, token FIFO entries; must be a power of 2, minimum 2.
- CNT_W, 16, width of the word counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state.
- in  input  8  ASCII byte.
- in_valid  input  1  in is consumed on this edge only when 1.
- eos  input  1  end of stream; terminates the word in progress.
- tok_ready  input  1  consumer accepts the head token this edge.
- tok_valid  output  1  FIFO not empty.
- tok_type  output  2  head token: 2'b01 BEGIN, 2'b10 END, 2'b11 OTHER; 2'b00 when empty.
- word_cnt  output  CNT_W  number of words terminated since reset; saturates at all-ones.
- overflow  output  1  sticky; a token was dropped because the FIFO was full.

Behaviour:
- Reset, asynchronous: FSM goes to IDLE, FIFO empties, tok_valid=0, tok_type=0, word_cnt=0, overflow=0. Reset mid-word discards the partial word; no token is emitted for it.
- Delimiter is 8'd32 (space) only. Every other byte is a word character.
- Letter compare is case-insensitive: {b,e,g,i,n,d} and their upper-case forms.
- FSM states: IDLE, B1 (b), B2 (be), B3 (beg), B4 (begi), BK (begin), E1 (e), E2 (en), EK (end), OTH.
- Transitions on a valid non-space byte:
  - IDLE: b->B1, e->E1, other->OTH.
  - B1: e->B2. B2: g->B3. B3: i->B4. B4: n->BK.
  - E1: n->E2. E2: d->EK.
  - Any mismatch, any byte in BK or EK, and OTH all go to OTH.
- Word termination: a valid space, or eos, while the FSM is not IDLE.
  - Push BEGIN if state is BK, END if state is EK, else OTHER.
  - Increment word_cnt (saturating).
  - FSM returns to IDLE.
- Valid space or eos while in IDLE: nothing happens. Leading, trailing and repeated spaces emit no tokens.
- in_valid=1 and eos=1 on the same edge:
  - A non-space byte is applied to the FSM first, then the word is terminated using the resulting state. Example: "en" followed by "d"+eos pushes END.
  - A space byte simply terminates the word; the termination is single, with no double push.
- eos with in_valid=0 terminates the current word if one is open.
- Latency: a token pushed on edge N is visible on tok_valid/tok_type after edge N (registered FIFO output path, no combinational in->tok path). tok_type reflects the FIFO head combinationally from the FIFO registers.
- Handshake:
  - A pop occurs on an edge with tok_valid & tok_ready.
  - tok_ready while empty has no effect.
  - The head is stable while tok_valid=1 and tok_ready=0.
- FIFO:
  - Circular buffer with read/write pointers of width log2(FIFO_DEPTH)+1; pointers wrap modulo 2*FIFO_DEPTH.
  - Full when the MSBs differ and the low bits are equal.
  - Push and pop on the same edge:
    - Non-empty FIFO: both take effect.
    - Full FIFO: the push is accepted and occupancy stays at FIFO_DEPTH.
    - Empty FIFO: only the push takes effect.
  - Push while full without a simultaneous pop: the token is dropped and overflow is set until reset. word_cnt still increments for the dropped word.
- No backpressure on the input: the block accepts one byte every clock.

Test Plan:
- "begin end" then eos with tok_ready=1 -> tokens 01 then 10, each one cycle after its terminator; word_cnt=2, overflow=0.
- "BeGiN" + eos on the same edge as "N" -> single token 01; word_cnt=1.
- "beginx en endd d" + eos -> tokens 11, 11, 11, 11; word_cnt=4.
- "   end   " with in_valid toggling 1/0 every cycle -> exactly one token 10; word_cnt=1; no token for the extra spaces.
- tok_ready=0, stream "a b c d e " with FIFO_DEPTH=4 -> tok_valid=1, FIFO holds 11x4, overflow=1, word_cnt=5. Then tok_ready=1 for 4 cycles -> 4 pops, tok_valid=0, overflow stays 1.
- Stream "begi", reset asserted asynchronously mid-cycle, then "end " -> during reset all outputs 0; afterwards only token 10; word_cnt=1.
